// File: rtl/elevador_entrada_cond.sv
// Input conditioning for the two-floor elevator controller: synchronises and
// debounces buttons and limit switches, latches mutually exclusive call requests.
module elevador_entrada_cond #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  input  logic sw_a_raw,
  input  logic sw_b_raw,
  output logic pa,
  output logic pb,
  output logic swa,
  output logic swb,
  output logic sw_conflict
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Channel order: 0 = btn_a, 1 = btn_b, 2 = sw_a, 3 = sw_b.
  logic [3:0] raw;
  logic [3:0] deb;

  assign raw = {sw_b_raw, sw_a_raw, btn_b_raw, btn_a_raw};

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count only runs while the synchronised level disagrees with deb,
    // so any bounce back to deb restarts the stability window.
    always_comb begin
      s1_d  = raw[gi];
      s2_d  = s1_q;
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (s2_q == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        deb_q <= deb_d;
        cnt_q <= cnt_d;
      end
    end

    assign deb[gi] = deb_q;
  end

  logic [1:0] edge_q, edge_d;
  logic [1:0] press;
  logic       req_a_q, req_a_d;
  logic       req_b_q, req_b_d;
  logic       conflict_q, conflict_d;
  logic       set_a, set_b;

  // A request is taken only when the other is idle; A wins a same-cycle tie.
  always_comb begin
    press      = deb[1:0] & ~edge_q;
    edge_d     = deb[1:0];
    conflict_d = deb[2] & deb[3];
    set_a      = press[0] & ~req_b_q & ~deb[2] & ~conflict_q;
    set_b      = press[1] & ~req_a_q & ~deb[3] & ~conflict_q & ~set_a;
    req_a_d    = req_a_q;
    req_b_d    = req_b_q;
    if (deb[2] | conflict_q) begin
      req_a_d = 1'b0;
    end else if (set_a) begin
      req_a_d = 1'b1;
    end
    if (deb[3] | conflict_q) begin
      req_b_d = 1'b0;
    end else if (set_b) begin
      req_b_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q     <= 2'b00;
      req_a_q    <= 1'b0;
      req_b_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      edge_q     <= edge_d;
      req_a_q    <= req_a_d;
      req_b_q    <= req_b_d;
      conflict_q <= conflict_d;
    end
  end

  assign pa          = req_a_q;
  assign pb          = req_b_q;
  assign swa         = deb[2];
  assign swb         = deb[3];
  assign sw_conflict = conflict_q;

endmodule

// File: tb/tb_elevador_entrada_cond.sv
// Bench for elevador_entrada_cond: directed scenarios plus random bouncing
// inputs, checked every cycle against a windowed reference model via a queue.
module tb_elevador_entrada_cond;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_a_raw = 1'b0;
  logic btn_b_raw = 1'b0;
  logic sw_a_raw = 1'b0;
  logic sw_b_raw = 1'b0;
  logic pa, pb, swa, swb, sw_conflict;
  logic [4:0] outs;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  elevador_entrada_cond #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .btn_a_raw(btn_a_raw),
    .btn_b_raw(btn_b_raw),
    .sw_a_raw(sw_a_raw),
    .sw_b_raw(sw_b_raw),
    .pa(pa),
    .pb(pb),
    .swa(swa),
    .swb(swb),
    .sw_conflict(sw_conflict)
  );

  always #5 clk = ~clk;

  // idx: 0 pa, 1 pb, 2 swa, 3 swb, 4 sw_conflict
  assign outs = {sw_conflict, swb, swa, pb, pa};

  // Reference model: a level is accepted once the last DEB synchronised
  // samples all disagree with the current accepted level.
  bit m_s1[4], m_s2[4], m_deb[4], m_edge[2];
  bit m_ra = 0, m_rb = 0, m_conf = 0;
  bit hist[4][DEB];
  int hcnt[4];
  logic [4:0] exp_q[$];

  always @(posedge clk) begin : model
    bit raw[4];
    bit od[4];
    bit pr_a, pr_b, take_a, take_b, all_diff, old_ra, old_rb;
    raw[0] = btn_a_raw;
    raw[1] = btn_b_raw;
    raw[2] = sw_a_raw;
    raw[3] = sw_b_raw;
    cycle++;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        m_s1[c] = 0;
        m_s2[c] = 0;
        m_deb[c] = 0;
        hcnt[c] = 0;
      end
      m_edge[0] = 0;
      m_edge[1] = 0;
      m_ra = 0;
      m_rb = 0;
      m_conf = 0;
    end else begin
      od = m_deb;
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < DEB - 1; k++) hist[c][k] = hist[c][k+1];
        hist[c][DEB-1] = m_s2[c];
        if (hcnt[c] < DEB) hcnt[c]++;
        all_diff = (hcnt[c] == DEB);
        for (int k = 0; k < DEB; k++) if (hist[c][k] == od[c]) all_diff = 0;
        if (all_diff) m_deb[c] = !od[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
      pr_a = od[0] && !m_edge[0];
      pr_b = od[1] && !m_edge[1];
      old_ra = m_ra;
      old_rb = m_rb;
      take_a = pr_a && !old_rb && !od[2] && !m_conf;
      take_b = pr_b && !old_ra && !od[3] && !m_conf && !take_a;
      if (od[2] || m_conf) m_ra = 0;
      else if (take_a) m_ra = 1;
      if (od[3] || m_conf) m_rb = 0;
      else if (take_b) m_rb = 1;
      m_conf = od[2] && od[3];
      m_edge[0] = od[0];
      m_edge[1] = od[1];
    end
    exp_q.push_back({m_conf, m_deb[3], m_deb[2], m_rb, m_ra});
  end

  // Monitor: compares every presented output sample with the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: got {conf,swb,swa,pb,pa}=%b required %b",
                 cycle, outs, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input int idx, input logic val, input string name);
    checks++;
    if (outs[idx] !== val) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, outs[idx], val);
    end
  endtask

  // Counts rising edges from the next (first sampling) edge until the output
  // reaches val; must be called right after an input change at a negedge.
  task automatic measure(input int idx, input logic val, input int exp_n, input string name);
    int n = 0;
    bit seen = 0;
    while (n < 50 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (outs[idx] === val) seen = 1;
    end
    checks++;
    if (!seen || n != exp_n) begin
      errors++;
      $display("FAIL %s: reached=%0d after %0d edges, required %0d edges", name, seen, n, exp_n);
    end else begin
      $display("latency %s: %0d edges", name, n);
    end
  endtask

  initial begin
    step(2);
    rst = 1'b0;

    // 1: idle after reset
    step(10);
    for (int i = 0; i < 5; i++) expect_out(i, 1'b0, "idle_zero");
    $display("scenario 1 idle done");

    // 2: bouncy A press with car at B
    sw_b_raw = 1'b1;
    step(10);
    btn_a_raw = 1'b1; step(1);
    btn_a_raw = 1'b0; step(1);
    btn_a_raw = 1'b1; step(1);
    btn_a_raw = 1'b0; step(1);
    btn_a_raw = 1'b1;
    measure(0, 1'b1, DEB + 3, "press_a_to_pa");
    step(3);
    btn_a_raw = 1'b0;
    step(10);
    expect_out(0, 1'b1, "pa_held_after_release");
    $display("scenario 2 bouncy press done");

    // 3: arrival at A clears pa; press while at A is ignored
    sw_b_raw = 1'b0;
    step(10);
    sw_a_raw = 1'b1;
    measure(2, 1'b1, DEB + 2, "sw_a_to_swa");
    measure(0, 1'b0, 1, "swa_to_pa_clear");
    btn_a_raw = 1'b1; step(8);
    btn_a_raw = 1'b0; step(8);
    expect_out(0, 1'b0, "press_at_a_ignored");
    $display("scenario 3 arrival done");

    // 4: simultaneous presses, A wins; B while pa pending dropped
    sw_a_raw = 1'b0;
    step(10);
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    measure(0, 1'b1, DEB + 3, "simul_pa");
    expect_out(1, 1'b0, "simul_pb_dropped");
    btn_a_raw = 1'b0;
    btn_b_raw = 1'b0;
    step(8);
    btn_b_raw = 1'b1; step(8);
    btn_b_raw = 1'b0; step(8);
    expect_out(1, 1'b0, "pb_while_pa_dropped");
    expect_out(0, 1'b1, "pa_kept");
    $display("scenario 4 exclusion done");

    // 5: switch conflict with pb pending
    sw_a_raw = 1'b1;
    step(10);
    btn_b_raw = 1'b1;
    measure(1, 1'b1, DEB + 3, "press_b_to_pb");
    btn_b_raw = 1'b0;
    step(8);
    sw_b_raw = 1'b1;
    measure(4, 1'b1, DEB + 3, "conflict_latency");
    expect_out(1, 1'b0, "pb_cleared_with_conflict");
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    step(8);
    expect_out(0, 1'b0, "conflict_pa_blocked");
    expect_out(1, 1'b0, "conflict_pb_blocked");
    btn_a_raw = 1'b0;
    btn_b_raw = 1'b0;
    step(8);
    sw_a_raw = 1'b0;
    sw_b_raw = 1'b0;
    step(12);
    expect_out(4, 1'b0, "conflict_cleared");
    expect_out(0, 1'b0, "no_late_pa");
    expect_out(1, 1'b0, "no_late_pb");
    $display("scenario 5 conflict done");

    // 6: reset aborts a pending request and debounce in progress
    btn_a_raw = 1'b1;
    measure(0, 1'b1, DEB + 3, "pre_reset_pa");
    btn_a_raw = 1'b0;
    btn_b_raw = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    btn_b_raw = 1'b0;
    for (int i = 0; i < 5; i++) expect_out(i, 1'b0, "reset_clears");
    step(8);
    btn_a_raw = 1'b1;
    measure(0, 1'b1, DEB + 3, "post_reset_pa");
    btn_a_raw = 1'b0;
    step(8);
    $display("scenario 6 reset done");

    // Random bouncing inputs with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_a_raw = ~btn_a_raw;
      if ($urandom_range(0, 5) == 0) btn_b_raw = ~btn_b_raw;
      if ($urandom_range(0, 11) == 0) sw_a_raw = ~sw_a_raw;
      if ($urandom_range(0, 11) == 0) sw_b_raw = ~sw_b_raw;
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    step(3);
    $display("random phase done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
